alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Reservation station directly upstream of execute_alu.
- Holds dispatched ALU/branch uops until both source operands are available, captures operand data from writeback broadcasts, and selects one ready entry per cycle.
- The selected entry goes into a registered issue slot driving execute_alu's uop, rs1/rs2 data and ROB tag inputs.

Parameters:
- DEPTH, 8, number of queue entries (power of two, >=2).
- TAG_W, 6, ROB/physical tag width.
- NUM_WB, 2, number of writeback broadcast ports.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush (mispredict or exception).
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  queue can accept a dispatch this cycle.
- disp_uop_i  in  decode_pkg::uop_t  decoded uop.
- disp_rob_tag_i  in  TAG_W  ROB tag of the uop.
- disp_rs1_ready_i / disp_rs2_ready_i  in  1  operand already available.
- disp_rs1_tag_i / disp_rs2_tag_i  in  TAG_W  producer tag when the operand is not ready.
- disp_rs1_data_i / disp_rs2_data_i  in  32  operand value when ready.
- wb_valid_i  in  NUM_WB  broadcast valid per port.
- wb_tag_i  in  NUM_WB*TAG_W  broadcast tags, packed.
- wb_data_i  in  NUM_WB*32  broadcast data, packed.
- alu_valid_o  out  1  issue slot holds a uop.
- alu_ready_i  in  1  execute_alu accepts the slot this cycle.
- alu_uop_o  out  decode_pkg::uop_t  issued uop.
- alu_rs1_data_o / alu_rs2_data_o  out  32  operand values.
- alu_rob_tag_o  out  TAG_W  issued ROB tag.
- count_o  out  $clog2(DEPTH)+1  current occupancy, excluding the issue slot.

Behaviour:
- Reset (async, rst_i=1): all entry valid bits 0; count_o=0; disp_ready_o=1; alu_valid_o=0; alu_uop_o, alu_rs*_data_o, alu_rob_tag_o = '0.
- Per-entry state: valid, uop, rob_tag, and per source {rdy, tag, data}.
- If uop.has_rs2=0, rs2 is forced ready with data 0 at dispatch.
- Dispatch: accepted when disp_valid_i && disp_ready_o && !flush_i.
  - Written into the lowest-index free entry.
  - disp_ready_o = (count < DEPTH), computed from registered state only.
  - A slot freed in the same cycle does not raise disp_ready_o until the next cycle.
- Wakeup: each cycle, every valid entry compares each non-ready source tag against all wb ports with wb_valid_i=1. On a match it sets rdy and captures data at the edge.
  - Dispatch-cycle capture: if a dispatched source is not ready and its tag matches a broadcast in the same cycle, the entry is written with rdy=1 and the wb data.
  - If several ports match one tag, the lowest port index wins.
- Select: candidates are valid entries with both sources rdy (registered state).
  - The lowest-index candidate is chosen when the issue slot is empty or being consumed (!alu_valid_o || alu_ready_i).
  - At the edge, the chosen entry moves into the issue slot and its valid bit clears.
- Issue slot: holds its contents stable while alu_valid_o && !alu_ready_i.
  - When consumed with no candidate, alu_valid_o goes 0 next cycle.
- Latency: a dispatch with both operands ready, into an empty queue with an empty slot, gives alu_valid_o=1 one cycle after acceptance. A wakeup in cycle N makes the entry selectable in cycle N+1.
- count_o: +1 on accepted dispatch, -1 on select; both in one cycle leaves it unchanged.
- flush_i (synchronous): at the next edge all entries invalid, count=0, alu_valid_o=0. Dispatch and select in the flush cycle are discarded.
- Simultaneous rst_i and flush_i: reset dominates.

Optional Feature:
- Macro: ALU_IQ_WB_BYPASS_EN.
- Defined: select also treats a source as ready when a matching broadcast is valid in the current cycle, and the issue slot captures the wb data directly. A wakeup in cycle N can issue at edge N, so alu_valid_o rises in N+1.
- Undefined: wakeup-to-select takes one extra cycle, as described above.

Test Plan:
- Reset, then dispatch ADD with rs1=0x10 and rs2=0x20 both ready, tag 3 -> next cycle alu_valid_o=1, alu_rs1_data_o=0x10, alu_rs2_data_o=0x20, alu_rob_tag_o=3; count_o returns to 0.
- Dispatch with rs1 waiting on tag 5; three cycles later wb_valid_i[1]=1, tag 5, data 0x1234 -> alu_valid_o=1 two cycles after the wb (one cycle with ALU_IQ_WB_BYPASS_EN), alu_rs1_data_o=0x1234.
- Hold alu_ready_i=0 with the slot full and two ready entries queued -> slot contents unchanged each cycle, count_o=2. Then raise alu_ready_i -> the lower-index entry issues next.
- DEPTH=8: dispatch 9 non-ready uops back to back -> disp_ready_o=0 after the 8th, the 9th is not accepted, count_o=8. Wake one entry -> disp_ready_o=1 one cycle after it is selected.
- Dispatch with rs2 tag 7 while wb broadcasts tag 7, data 0xBEEF in the same cycle -> the entry issues with alu_rs2_data_o=0xBEEF without any further broadcast.
- With 4 entries valid and the slot full, assert flush_i together with disp_valid_i -> next cycle count_o=0, alu_valid_o=0, and the dispatched uop never issues.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue -- reservation station in front of execute_alu.
//
// Purpose:
//   Buffers dispatched ALU/branch uops until both source operands are known,
//   snoops writeback broadcasts to fill missing operands, and each cycle moves
//   the lowest-index ready entry into a registered issue slot that feeds
//   execute_alu.
//
// Handshakes (valid/ready, transfer happens on a rising edge when both are 1):
//   dispatch : disp_valid_i / disp_ready_o. disp_ready_o depends only on
//              registered occupancy; a dispatch is dropped while flush_i=1.
//   issue    : alu_valid_o / alu_ready_i. Slot contents stay stable while
//              alu_valid_o=1 and alu_ready_i=0.
//
// Ports:
//   clk_i, rst_i (async, active high), flush_i (synchronous pipeline flush)
//   disp_*      : dispatched uop, ROB tag and per-source {ready, tag, data}
//   wb_*        : NUM_WB writeback broadcasts, tags/data packed, port 0 in LSBs
//   alu_*       : registered issue slot towards execute_alu
//   count_o     : entries held in the queue, not counting the issue slot
//
// Optional feature (macro ALU_IQ_WB_BYPASS_EN):
//   When defined, select also treats a source as ready if a matching broadcast
//   is valid this cycle, and the issue slot captures the broadcast data
//   directly, saving one cycle from wakeup to issue.

package decode_pkg;
    typedef struct packed {
        logic [4:0] op;
        logic       is_branch;
        logic       has_rs2;
        logic [4:0] rd;
    } uop_t;
endpackage

module alu_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int NUM_WB = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  decode_pkg::uop_t           disp_uop_i,
    input  logic [TAG_W-1:0]           disp_rob_tag_i,
    input  logic                       disp_rs1_ready_i,
    input  logic                       disp_rs2_ready_i,
    input  logic [TAG_W-1:0]           disp_rs1_tag_i,
    input  logic [TAG_W-1:0]           disp_rs2_tag_i,
    input  logic [31:0]                disp_rs1_data_i,
    input  logic [31:0]                disp_rs2_data_i,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag_i,
    input  logic [NUM_WB*32-1:0]       wb_data_i,
    output logic                       alu_valid_o,
    input  logic                       alu_ready_i,
    output decode_pkg::uop_t           alu_uop_o,
    output logic [31:0]                alu_rs1_data_o,
    output logic [31:0]                alu_rs2_data_o,
    output logic [TAG_W-1:0]           alu_rob_tag_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Entry state
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    decode_pkg::uop_t   uop_q [DEPTH];
    decode_pkg::uop_t   uop_d [DEPTH];
    logic [TAG_W-1:0]   rob_q [DEPTH];
    logic [TAG_W-1:0]   rob_d [DEPTH];
    logic [TAG_W-1:0]   rs1_tag_q [DEPTH];
    logic [TAG_W-1:0]   rs1_tag_d [DEPTH];
    logic [TAG_W-1:0]   rs2_tag_q [DEPTH];
    logic [TAG_W-1:0]   rs2_tag_d [DEPTH];
    logic [31:0]        rs1_data_q [DEPTH];
    logic [31:0]        rs1_data_d [DEPTH];
    logic [31:0]        rs2_data_q [DEPTH];
    logic [31:0]        rs2_data_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;

    // Issue slot state
    logic               alu_valid_q, alu_valid_d;
    decode_pkg::uop_t   alu_uop_q, alu_uop_d;
    logic [31:0]        alu_rs1_q, alu_rs1_d, alu_rs2_q, alu_rs2_d;
    logic [TAG_W-1:0]   alu_rob_q, alu_rob_d;

    // Select / dispatch helpers
    logic [DEPTH-1:0]   cand;
    logic [IDX_W-1:0]   sel_idx, free_idx;
    logic               slot_free, do_sel, accept;

    // True when any valid broadcast carries this tag.
    function automatic logic wb_hit(input logic [TAG_W-1:0] tag,
                                    input logic [NUM_WB-1:0] v,
                                    input logic [NUM_WB*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NUM_WB; p++)
            if (v[p] && tags[p*TAG_W +: TAG_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    // Data of the lowest-index matching broadcast (scan downwards so the
    // lowest match is written last).
    function automatic logic [31:0] wb_pick(input logic [TAG_W-1:0] tag,
                                            input logic [NUM_WB-1:0] v,
                                            input logic [NUM_WB*TAG_W-1:0] tags,
                                            input logic [NUM_WB*32-1:0] data);
        logic [31:0] d;
        d = '0;
        for (int p = NUM_WB - 1; p >= 0; p--)
            if (v[p] && tags[p*TAG_W +: TAG_W] == tag) d = data[p*32 +: 32];
        return d;
    endfunction

    assign disp_ready_o   = (count_q != CNT_W'(DEPTH));
    assign count_o        = count_q;
    assign alu_valid_o    = alu_valid_q;
    assign alu_uop_o      = alu_uop_q;
    assign alu_rs1_data_o = alu_rs1_q;
    assign alu_rs2_data_o = alu_rs2_q;
    assign alu_rob_tag_o  = alu_rob_q;

    // Candidate vector and lowest-index pick for select and for free slot.
    always_comb begin
        cand     = '0;
        sel_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef ALU_IQ_WB_BYPASS_EN
            cand[i] = valid_q[i]
                && (rs1_rdy_q[i] || wb_hit(rs1_tag_q[i], wb_valid_i, wb_tag_i))
                && (rs2_rdy_q[i] || wb_hit(rs2_tag_q[i], wb_valid_i, wb_tag_i));
`else
            cand[i] = valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i];
`endif
            if (cand[i])     sel_idx  = IDX_W'(i);
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d     = valid_q;
        rs1_rdy_d   = rs1_rdy_q;
        rs2_rdy_d   = rs2_rdy_q;
        uop_d       = uop_q;
        rob_d       = rob_q;
        rs1_tag_d   = rs1_tag_q;
        rs2_tag_d   = rs2_tag_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        alu_valid_d = alu_valid_q;
        alu_uop_d   = alu_uop_q;
        alu_rs1_d   = alu_rs1_q;
        alu_rs2_d   = alu_rs2_q;
        alu_rob_d   = alu_rob_q;

        // Wakeup: fill waiting sources from this cycle's broadcasts.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !rs1_rdy_q[i] && wb_hit(rs1_tag_q[i], wb_valid_i, wb_tag_i)) begin
                rs1_rdy_d[i]  = 1'b1;
                rs1_data_d[i] = wb_pick(rs1_tag_q[i], wb_valid_i, wb_tag_i, wb_data_i);
            end
            if (valid_q[i] && !rs2_rdy_q[i] && wb_hit(rs2_tag_q[i], wb_valid_i, wb_tag_i)) begin
                rs2_rdy_d[i]  = 1'b1;
                rs2_data_d[i] = wb_pick(rs2_tag_q[i], wb_valid_i, wb_tag_i, wb_data_i);
            end
        end

        // Select into the issue slot.
        slot_free = !alu_valid_q || alu_ready_i;
        do_sel    = slot_free && (|cand);
        if (slot_free) begin
            alu_valid_d = do_sel;
            if (do_sel) begin
                valid_d[sel_idx] = 1'b0;
                alu_uop_d        = uop_q[sel_idx];
                alu_rob_d        = rob_q[sel_idx];
`ifdef ALU_IQ_WB_BYPASS_EN
                alu_rs1_d = rs1_rdy_q[sel_idx] ? rs1_data_q[sel_idx]
                          : wb_pick(rs1_tag_q[sel_idx], wb_valid_i, wb_tag_i, wb_data_i);
                alu_rs2_d = rs2_rdy_q[sel_idx] ? rs2_data_q[sel_idx]
                          : wb_pick(rs2_tag_q[sel_idx], wb_valid_i, wb_tag_i, wb_data_i);
`else
                alu_rs1_d = rs1_data_q[sel_idx];
                alu_rs2_d = rs2_data_q[sel_idx];
`endif
            end
        end

        // Dispatch into the lowest free entry (free by registered state, so
        // an entry vacated by this cycle's select is reused only next cycle).
        accept = disp_valid_i && disp_ready_o && !flush_i;
        if (accept) begin
            valid_d[free_idx]   = 1'b1;
            uop_d[free_idx]     = disp_uop_i;
            rob_d[free_idx]     = disp_rob_tag_i;
            rs1_tag_d[free_idx] = disp_rs1_tag_i;
            rs2_tag_d[free_idx] = disp_rs2_tag_i;
            if (disp_rs1_ready_i) begin
                rs1_rdy_d[free_idx]  = 1'b1;
                rs1_data_d[free_idx] = disp_rs1_data_i;
            end else begin
                rs1_rdy_d[free_idx]  = wb_hit(disp_rs1_tag_i, wb_valid_i, wb_tag_i);
                rs1_data_d[free_idx] = wb_pick(disp_rs1_tag_i, wb_valid_i, wb_tag_i, wb_data_i);
            end
            if (!disp_uop_i.has_rs2) begin
                rs2_rdy_d[free_idx]  = 1'b1;
                rs2_data_d[free_idx] = '0;
            end else if (disp_rs2_ready_i) begin
                rs2_rdy_d[free_idx]  = 1'b1;
                rs2_data_d[free_idx] = disp_rs2_data_i;
            end else begin
                rs2_rdy_d[free_idx]  = wb_hit(disp_rs2_tag_i, wb_valid_i, wb_tag_i);
                rs2_data_d[free_idx] = wb_pick(disp_rs2_tag_i, wb_valid_i, wb_tag_i, wb_data_i);
            end
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(do_sel);

        // Flush drops every entry and the slot; this cycle's select is void.
        if (flush_i) begin
            valid_d     = '0;
            count_d     = '0;
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            rs1_rdy_q   <= '0;
            rs2_rdy_q   <= '0;
            count_q     <= '0;
            alu_valid_q <= 1'b0;
            alu_uop_q   <= '0;
            alu_rs1_q   <= '0;
            alu_rs2_q   <= '0;
            alu_rob_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            rs1_rdy_q   <= rs1_rdy_d;
            rs2_rdy_q   <= rs2_rdy_d;
            count_q     <= count_d;
            alu_valid_q <= alu_valid_d;
            alu_uop_q   <= alu_uop_d;
            alu_rs1_q   <= alu_rs1_d;
            alu_rs2_q   <= alu_rs2_d;
            alu_rob_q   <= alu_rob_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            uop_q[i]      <= uop_d[i];
            rob_q[i]      <= rob_d[i];
            rs1_tag_q[i]  <= rs1_tag_d[i];
            rs2_tag_q[i]  <= rs2_tag_d[i];
            rs1_data_q[i] <= rs1_data_d[i];
            rs2_data_q[i] <= rs2_data_d[i];
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset values, ready dispatch, wakeup
// latency, lowest-port priority, has_rs2=0, hold under backpressure, full
// queue, same-cycle capture, flush and reset-over-flush.
module tb_alu_issue_queue;
    import decode_pkg::*;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 6;
    localparam int NUM_WB = 2;

    logic                    clk = 1'b0;
    logic                    rst, flush;
    logic                    disp_valid, disp_ready;
    uop_t                    disp_uop;
    logic [TAG_W-1:0]        disp_rob, disp_rs1_tag, disp_rs2_tag;
    logic                    disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0]             disp_rs1_data, disp_rs2_data;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*32-1:0]    wb_data;
    logic                    alu_valid, alu_ready;
    uop_t                    alu_uop;
    logic [31:0]             alu_rs1, alu_rs2;
    logic [TAG_W-1:0]        alu_rob;
    logic [3:0]              count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
        .disp_uop_i(disp_uop), .disp_rob_tag_i(disp_rob),
        .disp_rs1_ready_i(disp_rs1_rdy), .disp_rs2_ready_i(disp_rs2_rdy),
        .disp_rs1_tag_i(disp_rs1_tag), .disp_rs2_tag_i(disp_rs2_tag),
        .disp_rs1_data_i(disp_rs1_data), .disp_rs2_data_i(disp_rs2_data),
        .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
        .alu_valid_o(alu_valid), .alu_ready_i(alu_ready), .alu_uop_o(alu_uop),
        .alu_rs1_data_o(alu_rs1), .alu_rs2_data_o(alu_rs2),
        .alu_rob_tag_o(alu_rob), .count_o(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [TAG_W-1:0] rob, input logic has2,
                        input logic r1rdy, input logic [TAG_W-1:0] r1tag, input logic [31:0] r1data,
                        input logic r2rdy, input logic [TAG_W-1:0] r2tag, input logic [31:0] r2data);
        disp_valid       = 1'b1;
        disp_uop         = '0;
        disp_uop.op      = 5'd1;
        disp_uop.has_rs2 = has2;
        disp_uop.rd      = 5'd7;
        disp_rob         = rob;
        disp_rs1_rdy     = r1rdy;
        disp_rs1_tag     = r1tag;
        disp_rs1_data    = r1data;
        disp_rs2_rdy     = r2rdy;
        disp_rs2_tag     = r2tag;
        disp_rs2_data    = r2data;
    endtask

    task automatic idle_disp();
        disp_valid = 1'b0;
    endtask

    task automatic wb_set(input logic [1:0] v, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
                          input logic [TAG_W-1:0] t1, input logic [31:0] d1);
        wb_valid = v;
        wb_tag   = {t1, t0};
        wb_data  = {d1, d0};
    endtask

    task automatic wb_clear();
        wb_valid = '0;
        wb_tag   = '0;
        wb_data  = '0;
    endtask

    // Extra cycle between a wakeup edge and issue when there is no bypass.
    task automatic wake_to_issue();
`ifndef ALU_IQ_WB_BYPASS_EN
        check("no_issue_before_wake_latency", {31'b0, alu_valid}, 32'd0);
        step();
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alu_ready = 1'b1;
        disp_valid = 1'b0; disp_uop = '0; disp_rob = '0;
        disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_tag = '0; disp_rs2_tag = '0;
        disp_rs1_data = '0; disp_rs2_data = '0;
        wb_clear();
        step(); step();
        check("rst_count", {28'b0, count}, 32'd0);
        check("rst_disp_ready", {31'b0, disp_ready}, 32'd1);
        check("rst_alu_valid", {31'b0, alu_valid}, 32'd0);
        check("rst_alu_rs1", alu_rs1, 32'd0);
        check("rst_alu_rob", {26'b0, alu_rob}, 32'd0);
        rst = 1'b0;
        step();

        // Both operands ready: entry at the accept edge, slot one edge later.
        disp(6'd3, 1'b1, 1'b1, 6'd0, 32'h10, 1'b1, 6'd0, 32'h20);
        step();
        idle_disp();
        check("add_count_after_accept", {28'b0, count}, 32'd1);
        check("add_not_yet_valid", {31'b0, alu_valid}, 32'd0);
        step();
        check("add_valid", {31'b0, alu_valid}, 32'd1);
        check("add_rs1", alu_rs1, 32'h10);
        check("add_rs2", alu_rs2, 32'h20);
        check("add_rob", {26'b0, alu_rob}, 32'd3);
        check("add_count_back_to_0", {28'b0, count}, 32'd0);

        // rs1 waits on tag 5; broadcast three cycles later on port 1.
        disp(6'd4, 1'b1, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h2);
        step();
        idle_disp();
        check("wait_not_issued_1", {31'b0, alu_valid}, 32'd0);
        step();
        check("wait_not_issued_2", {31'b0, alu_valid}, 32'd0);
        step();
        wb_set(2'b11, 6'd9, 32'hDEAD, 6'd5, 32'h1234);
        step();
        wb_clear();
        wake_to_issue();
        check("wake_valid", {31'b0, alu_valid}, 32'd1);
        check("wake_rs1", alu_rs1, 32'h1234);
        check("wake_rs2", alu_rs2, 32'h2);
        check("wake_rob", {26'b0, alu_rob}, 32'd4);

        // Two ports broadcast the same tag: port 0 data wins.
        disp(6'd14, 1'b1, 1'b0, 6'd6, 32'h0, 1'b1, 6'd0, 32'h3);
        step();
        idle_disp();
        wb_set(2'b11, 6'd6, 32'hAAAA, 6'd6, 32'hBBBB);
        step();
        wb_clear();
        wake_to_issue();
        check("lowport_valid", {31'b0, alu_valid}, 32'd1);
        check("lowport_rs1", alu_rs1, 32'hAAAA);

        // has_rs2=0 forces rs2 ready with data 0, whatever dispatch drives.
        disp(6'd15, 1'b0, 1'b1, 6'd0, 32'h11, 1'b0, 6'd9, 32'h999);
        step();
        idle_disp();
        step();
        check("norrs2_valid", {31'b0, alu_valid}, 32'd1);
        check("norrs2_rs2_zero", alu_rs2, 32'd0);
        check("norrs2_rob", {26'b0, alu_rob}, 32'd15);
        step();
        check("drain_before_hold", {31'b0, alu_valid}, 32'd0);

        // Backpressure: A goes to the slot, B to entry 1, C reuses entry 0.
        alu_ready = 1'b0;
        disp(6'd10, 1'b1, 1'b1, 6'd0, 32'hA1, 1'b1, 6'd0, 32'hA2);
        step();
        disp(6'd11, 1'b1, 1'b1, 6'd0, 32'hB1, 1'b1, 6'd0, 32'hB2);
        step();
        disp(6'd12, 1'b1, 1'b1, 6'd0, 32'hC1, 1'b1, 6'd0, 32'hC2);
        step();
        idle_disp();
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", {31'b0, alu_valid}, 32'd1);
            check("hold_rob", {26'b0, alu_rob}, 32'd10);
            check("hold_rs1", alu_rs1, 32'hA1);
            check("hold_count", {28'b0, count}, 32'd2);
            step();
        end
        alu_ready = 1'b1;
        check("release_still_a", {26'b0, alu_rob}, 32'd10);
        step();
        check("release_entry0_first", {26'b0, alu_rob}, 32'd12);
        check("release_entry0_rs1", alu_rs1, 32'hC1);
        check("release_count_1", {28'b0, count}, 32'd1);
        step();
        check("release_entry1_next", {26'b0, alu_rob}, 32'd11);
        check("release_count_0", {28'b0, count}, 32'd0);
        step();
        check("release_drained", {31'b0, alu_valid}, 32'd0);

        // Dispatch-cycle capture of rs2 from a same-cycle broadcast.
        disp(6'd13, 1'b1, 1'b1, 6'd0, 32'h5, 1'b0, 6'd7, 32'h0);
        wb_set(2'b01, 6'd7, 32'hBEEF, 6'd0, 32'h0);
        step();
        idle_disp();
        wb_clear();
        check("cap_count", {28'b0, count}, 32'd1);
        step();
        check("cap_valid", {31'b0, alu_valid}, 32'd1);
        check("cap_rs2", alu_rs2, 32'hBEEF);
        check("cap_rob", {26'b0, alu_rob}, 32'd13);
        step();
        check("cap_drained", {31'b0, alu_valid}, 32'd0);

        // Fill all 8 entries with waiting uops; the 9th must be refused.
        alu_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            disp(6'(30 + i), 1'b1, 1'b0, 6'(20 + i), 32'h0, 1'b1, 6'd0, 32'h1);
            check("full_disp_ready", {31'b0, disp_ready}, (i < 8) ? 32'd1 : 32'd0);
            step();
        end
        idle_disp();
        check("full_count", {28'b0, count}, 32'd8);
        check("full_ready_low", {31'b0, disp_ready}, 32'd0);
        wb_set(2'b01, 6'd23, 32'h77, 6'd0, 32'h0);
        step();
        wb_clear();
`ifdef ALU_IQ_WB_BYPASS_EN
        check("full_wake_count", {28'b0, count}, 32'd7);
        check("full_wake_ready", {31'b0, disp_ready}, 32'd1);
`else
        check("full_wake_count", {28'b0, count}, 32'd8);
        check("full_wake_ready", {31'b0, disp_ready}, 32'd0);
        step();
        check("full_sel_count", {28'b0, count}, 32'd7);
        check("full_sel_ready", {31'b0, disp_ready}, 32'd1);
`endif
        check("full_issue_valid", {31'b0, alu_valid}, 32'd1);
        check("full_issue_rob", {26'b0, alu_rob}, 32'd33);
        check("full_issue_rs1", alu_rs1, 32'h77);

        // Flush with entries queued, slot full, and a dispatch in flight.
        flush = 1'b1;
        disp(6'd50, 1'b1, 1'b1, 6'd0, 32'h50, 1'b1, 6'd0, 32'h51);
        step();
        flush = 1'b0;
        idle_disp();
        check("flush_count", {28'b0, count}, 32'd0);
        check("flush_valid", {31'b0, alu_valid}, 32'd0);
        check("flush_ready", {31'b0, disp_ready}, 32'd1);
        alu_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_no_issue", {31'b0, alu_valid}, 32'd0);
        end

        // Reset and flush together: reset clears state asynchronously.
        disp(6'd60, 1'b1, 1'b0, 6'd40, 32'h0, 1'b1, 6'd0, 32'h1);
        step();
        idle_disp();
        check("pre_rst_count", {28'b0, count}, 32'd1);
        rst = 1'b1;
        flush = 1'b1;
        #1;
        check("async_rst_count", {28'b0, count}, 32'd0);
        step();
        check("rst_flush_count", {28'b0, count}, 32'd0);
        check("rst_flush_valid", {31'b0, alu_valid}, 32'd0);
        check("rst_flush_ready", {31'b0, disp_ready}, 32'd1);
        rst = 1'b0;
        flush = 1'b0;
        step();
        check("post_rst_count", {28'b0, count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
